// File: rtl/testport_write_monitor.sv
`default_nettype none
// ============================================================================
// Module   : testport_write_monitor
// Brief    : Captures CPU stores to the test port, collapses stalled writes
//            into single events, byte-swaps them into readable order, frames
//            the stream with begin/end symbols and queues the words for the
//            result checker over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module testport_write_monitor #(
   parameter logic [29:0] TEST_PORT    = 30'h10,
   parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
   parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
   parameter int          DEPTH        = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] addr,
   input  logic [31:0] data,
   input  logic        wen,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        armed,
   output logic        done,
   output logic [7:0]  word_count,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            wen_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [7:0]      word_count_q, word_count_d;
   logic            overflow_q, overflow_d;
   logic [32:0]     mem_q [DEPTH];

   logic [31:0]     swapped;
   logic            is_last;
   logic            wr_event;
   logic            push_req;
   logic            push_ok;
   logic            pop;
   logic            clr_count;
   logic [32:0]     head;

   // Bus data is little-endian; the checker wants the most significant byte first.
   assign swapped  = {data[7:0], data[15:8], data[23:16], data[31:24]};
   assign is_last  = (swapped == END_SYMBOL);
   // Only the rising edge of wen counts, so a write held through a stall is one event.
   assign wr_event = wen & ~wen_q & (addr == TEST_PORT);

   // Registers the FSM state and the previous write enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen;
      end
   end

   // Framing FSM: arm on the begin word, queue data while armed, stop after the end word.
   always_comb begin
      state_d   = state_q;
      push_req  = 1'b0;
      clr_count = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_event && (swapped == BEGIN_SYMBOL)) begin
               state_d   = S_ARMED;
               clr_count = 1'b1;
            end
         end
         S_ARMED: begin
            if (wr_event) begin
               push_req = 1'b1;
               if (is_last) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A full FIFO (MSB of count set) still accepts a word when the head leaves in the same cycle.
   assign pop     = (count_q != '0) & out_ready;
   assign push_ok = push_req & (~count_q[AW] | pop);

   // Next-state logic for FIFO pointers, occupancy and capture statistics.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (push_req && !push_ok) begin
         overflow_d = 1'b1;
      end
      if (clr_count) begin
         word_count_d = 8'd0;
      end else if (push_ok && (word_count_q != 8'hFF)) begin
         word_count_d = word_count_q + 8'd1;
      end
   end

   // Registers FIFO control and capture statistics.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         word_count_q <= 8'd0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
      end
   end

   // FIFO storage; contents are only observed through count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {is_last, swapped};
      end
   end

   // The head is forced to zero while empty so the outputs read zero out of reset.
   assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : 33'd0;
   assign out_valid  = (count_q != '0);
   assign out_data   = head[31:0];
   assign out_last   = head[32];
   assign armed      = (state_q == S_ARMED);
   assign done       = (state_q == S_DONE);
   assign word_count = word_count_q;
   assign overflow   = overflow_q;

endmodule
`default_nettype wire
